// File: rtl/dtlb_cache_pkg.sv
// Shared state encodings and kseg0/kseg1 address-segment decode for the DTLB cache.
// The main TLB answers one cycle after tlb_vaddr changes; the FSM is built around that.
package dtlb_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    localparam logic [2:0] CATTR_UNCACHED = 3'd2;
    localparam logic [1:0] SEG_UNMAPPED   = 2'b10;
    localparam logic       SEG_KSEG1      = 1'b1;

    function automatic logic is_unmapped(input logic [31:0] vaddr);
        return vaddr[31:30] == SEG_UNMAPPED;
    endfunction

endpackage

// File: rtl/dtlb_cache_onehot_enc.sv
// One-hot match vector to binary entry index; purely combinational.
// An all-zero input yields index 0, so callers qualify the result with their own hit flag.
module dtlb_cache_onehot_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx |= W'(i);
        end
    end

endmodule

// File: rtl/dtlb_cache.sv
// Small translation cache in front of the main TLB: hits and unmapped segments answer in the
// same cycle, misses answer two cycles later; the requester holds its request until resp_valid.
module dtlb_cache
    import dtlb_cache_pkg::*;
#(
    parameter int ENTRIES    = 4,
    parameter int VPN_W      = 20,
    parameter int CACHE_MISS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    input  logic        req_write,
    input  logic [2:0]  config_k0,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_miss,
    output logic        resp_invalid,
    output logic        resp_dirty,
    output logic [2:0]  resp_cattr,
    output logic [31:0] tlb_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_invalid,
    input  logic        tlb_dirty,
    input  logic [2:0]  tlb_cattr
);

    localparam int OFF_W = 32 - VPN_W;
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    state_t state, state_nxt;

    logic [ENTRIES-1:0] ent_vld;
    logic [VPN_W-1:0]   ent_vpn   [ENTRIES];
    logic [VPN_W-1:0]   ent_ppn   [ENTRIES];
    logic [ENTRIES-1:0] ent_miss, ent_inv, ent_dirty;
    logic [2:0]         ent_cattr [ENTRIES];

    logic [IDX_W-1:0] victim, fill_idx, hit_idx;
    logic             fill_byp;
    logic [VPN_W-1:0] byp_ppn;
    logic             byp_miss, byp_inv, byp_dirty;
    logic [2:0]       byp_cattr;

    logic [ENTRIES-1:0] match;
    logic               hit, unmapped, to_bypass, do_fill;
    logic               unused_ok;

    assign unused_ok = ^{req_write, tlb_paddr[OFF_W-1:0]};
    assign unmapped  = is_unmapped(req_vaddr);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = ent_vld[i] && (ent_vpn[i] == req_vaddr[31:OFF_W]);
        end
    end
    assign hit = |match;

    dtlb_cache_onehot_enc #(.N(ENTRIES), .W(IDX_W)) u_enc (
        .onehot (match),
        .idx    (hit_idx)
    );

    // Without miss caching, faulting translations are parked in the bypass register instead.
    assign to_bypass = (CACHE_MISS == 0) && (tlb_miss || tlb_invalid);
    assign do_fill   = (state == ST_QUERY) && !flush && !to_bypass;

    always_comb begin
        state_nxt    = state;
        resp_valid   = 1'b0;
        resp_paddr   = '0;
        resp_miss    = 1'b0;
        resp_invalid = 1'b0;
        resp_dirty   = 1'b0;
        resp_cattr   = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (unmapped) begin
                        resp_valid = 1'b1;
                        resp_paddr = {3'b000, req_vaddr[28:0]};
                        resp_cattr = (req_vaddr[29] == SEG_KSEG1) ? CATTR_UNCACHED : config_k0;
                    end else if (hit) begin
                        resp_valid   = 1'b1;
                        resp_paddr   = {ent_ppn[hit_idx], req_vaddr[OFF_W-1:0]};
                        resp_miss    = ent_miss[hit_idx];
                        resp_invalid = ent_inv[hit_idx];
                        resp_dirty   = ent_dirty[hit_idx];
                        resp_cattr   = ent_cattr[hit_idx];
                    end else begin
                        state_nxt = ST_QUERY;
                    end
                end
            end
            ST_QUERY: state_nxt = flush ? ST_IDLE : ST_FILL;
            ST_FILL: begin
                // Offset comes from tlb_vaddr: the requester may already have dropped req_vaddr.
                resp_valid = 1'b1;
                if (fill_byp) begin
                    resp_paddr   = {byp_ppn, tlb_vaddr[OFF_W-1:0]};
                    resp_miss    = byp_miss;
                    resp_invalid = byp_inv;
                    resp_dirty   = byp_dirty;
                    resp_cattr   = byp_cattr;
                end else begin
                    resp_paddr   = {ent_ppn[fill_idx], tlb_vaddr[OFF_W-1:0]};
                    resp_miss    = ent_miss[fill_idx];
                    resp_invalid = ent_inv[fill_idx];
                    resp_dirty   = ent_dirty[fill_idx];
                    resp_cattr   = ent_cattr[fill_idx];
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) resp_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ent_vld   <= '0;
            victim    <= '0;
            fill_idx  <= '0;
            fill_byp  <= 1'b0;
            tlb_vaddr <= '0;
            byp_ppn   <= '0;
            byp_miss  <= 1'b0;
            byp_inv   <= 1'b0;
            byp_dirty <= 1'b0;
            byp_cattr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid && !unmapped && !hit) tlb_vaddr <= req_vaddr;
            if (flush) begin
                ent_vld <= '0;
            end else if (state == ST_QUERY) begin
                if (to_bypass) begin
                    fill_byp  <= 1'b1;
                    byp_ppn   <= tlb_paddr[31:OFF_W];
                    byp_miss  <= tlb_miss;
                    byp_inv   <= tlb_invalid;
                    byp_dirty <= tlb_dirty;
                    byp_cattr <= tlb_cattr;
                end else begin
                    fill_byp        <= 1'b0;
                    fill_idx        <= victim;
                    ent_vld[victim] <= 1'b1;
                    victim          <= (victim == IDX_W'(ENTRIES - 1)) ? '0 : victim + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_fill) begin
            ent_vpn[victim]   <= tlb_vaddr[31:OFF_W];
            ent_ppn[victim]   <= tlb_paddr[31:OFF_W];
            ent_miss[victim]  <= tlb_miss;
            ent_inv[victim]   <= tlb_invalid;
            ent_dirty[victim] <= tlb_dirty;
            ent_cattr[victim] <= tlb_cattr;
        end
    end

endmodule
